// File: rtl/dspl_mux_drv.sv
// Time-multiplexed common-anode 7-segment driver: digit scan, glyph decode, PWM dimming, anti-ghost blank.
// Optional blinking of selected digits is compiled in when DSPL_BLINK_EN is defined.
module dspl_mux_drv #(
    parameter int N_DIG      = 8,
    parameter int TICK_COUNT = 100000,
    parameter int DIM_BITS   = 3,
    parameter int BLINK_FR   = 250
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [6*N_DIG-1:0]   dig_bus,
    input  logic [DIM_BITS-1:0]  bright,
    input  logic [N_DIG-1:0]     blink_mask,
    output logic [N_DIG-1:0]     an,
    output logic [7:0]           dec_ddp,
    output logic                 slot_strobe,
    output logic                 frame_done
);
    localparam int PW = $clog2(TICK_COUNT);
    localparam int IW = (N_DIG > 1) ? $clog2(N_DIG) : 1;
    localparam logic [PW-1:0] P_LAST   = PW'(TICK_COUNT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIG - 1);

    function automatic logic [6:0] seg7(input logic [3:0] c);
        case (c)
            4'h0: seg7 = 7'b0000001;  4'h1: seg7 = 7'b1001111;
            4'h2: seg7 = 7'b0010010;  4'h3: seg7 = 7'b0000110;
            4'h4: seg7 = 7'b1001100;  4'h5: seg7 = 7'b0100100;
            4'h6: seg7 = 7'b0100000;  4'h7: seg7 = 7'b0001111;
            4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b1110001;
            4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b1000111;
            4'hC: seg7 = 7'b1000001;  4'hD: seg7 = 7'b0011000;
            4'hE: seg7 = 7'b0110000;  default: seg7 = 7'b0111000;
        endcase
    endfunction

    logic [PW-1:0]       pre_q, pre_d;
    logic [DIM_BITS-1:0] pwm_q, pwm_d;
    logic [IW-1:0]       index_q, index_d;
    logic                started_q, started_d;
    logic                en_q, en_d;
    logic [N_DIG-1:0]    an_q, an_d;
    logic [7:0]          dec_q, dec_d;
    logic                slot_q, slot_d, frame_q, frame_d;
    logic                tick, wrap, pwm_on, blank, mask_sel;
    logic [5:0]          word_sel;

`ifdef DSPL_BLINK_EN
    localparam int FW = (BLINK_FR > 1) ? $clog2(BLINK_FR) : 1;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (wrap) begin
            if (fcnt_q == FW'(BLINK_FR - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            fcnt_q  <= fcnt_d;
            phase_q <= phase_d;
        end
    end

    assign blank = phase_q & mask_sel;
`else
    logic unused_blink;
    assign unused_blink = ^{mask_sel, blink_mask};
    assign blank = 1'b0;
`endif

    always_comb begin
        tick  = (pre_q == P_LAST);
        pre_d = tick ? '0 : pre_q + 1'b1;
        pwm_d = pwm_q + 1'b1;
        // The first tick after reset presents digit 0 rather than advancing past it.
        wrap      = tick && (index_q == IDX_LAST) && (started_q || (N_DIG == 1));
        index_d   = index_q;
        started_d = started_q;
        if (tick) begin
            started_d = 1'b1;
            index_d   = (!started_q || index_q == IDX_LAST) ? '0 : index_q + 1'b1;
        end

        word_sel = '0;
        mask_sel = 1'b0;
        for (int k = 0; k < N_DIG; k++) begin
            if (index_d == IW'(k)) word_sel = dig_bus[6*k +: 6];
            if (index_q == IW'(k)) mask_sel = blink_mask[k];
        end

        // Anode state is registered, so it is judged against the pwm count of the clock it appears on.
        pwm_on = (pwm_d <= bright);
        en_d   = tick ? word_sel[5] : en_q;
        an_d   = '1;
        for (int k = 0; k < N_DIG; k++)
            if (!tick && index_q == IW'(k)) an_d[k] = ~(en_q & pwm_on & ~blank);
        dec_d = tick ? {seg7(word_sel[4:1]), word_sel[0]} : dec_q;

        slot_d  = (pre_d == P_LAST);
        frame_d = slot_d && (index_d == IDX_LAST) && (started_d || (N_DIG == 1));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pre_q     <= '0;
            pwm_q     <= '0;
            index_q   <= '0;
            started_q <= 1'b0;
            en_q      <= 1'b0;
            an_q      <= '1;
            dec_q     <= 8'hFF;
            slot_q    <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            pwm_q     <= pwm_d;
            index_q   <= index_d;
            started_q <= started_d;
            en_q      <= en_d;
            an_q      <= an_d;
            dec_q     <= dec_d;
            slot_q    <= slot_d;
            frame_q   <= frame_d;
        end
    end

    assign an          = an_q;
    assign dec_ddp     = dec_q;
    assign slot_strobe = slot_q;
    assign frame_done  = frame_q;
endmodule

// File: tb/tb_dspl_mux_drv.sv
// Directed bench for dspl_mux_drv: one frame table plus hand sequences for PWM, latching, reset and blink.
module tb_dspl_mux_drv;
    logic        clock = 1'b0;
    logic        reset;
    logic [23:0] dig_bus;
    logic [1:0]  bright;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [7:0]  dec_ddp;
    logic        slot_strobe, frame_done;

    int n_chk = 0;
    int n_pass = 0;

    dspl_mux_drv #(.N_DIG(4), .TICK_COUNT(4), .DIM_BITS(2), .BLINK_FR(2)) dut (
        .clock(clock), .reset(reset), .dig_bus(dig_bus), .bright(bright),
        .blink_mask(blink_mask), .an(an), .dec_ddp(dec_ddp),
        .slot_strobe(slot_strobe), .frame_done(frame_done)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0] an;
        logic [7:0] dec;
        logic       s;
        logic       f;
    } vec_t;
    vec_t tbl[16];

    function automatic logic [5:0] dg(input logic en, input logic [3:0] code, input logic dp);
        return {en, code, dp};
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [3:0] e_an, input logic [7:0] e_dec,
                       input logic e_s, input logic e_f);
        n_chk++;
        if (an === e_an && dec_ddp === e_dec && slot_strobe === e_s && frame_done === e_f)
            n_pass++;
        else
            $display("FAIL %s: got an=%b dec=%h s=%b f=%b, want an=%b dec=%h s=%b f=%b",
                     name, an, dec_ddp, slot_strobe, frame_done, e_an, e_dec, e_s, e_f);
    endtask

    initial begin
        // digits 0..3 = codes 1,2,3,4 with dp=1; digit 2 disabled
        tbl[0]  = '{4'hF, 8'h9F, 0, 0};
        tbl[1]  = '{4'hE, 8'h9F, 0, 0};
        tbl[2]  = '{4'hE, 8'h9F, 0, 0};
        tbl[3]  = '{4'hE, 8'h9F, 1, 0};
        tbl[4]  = '{4'hF, 8'h25, 0, 0};
        tbl[5]  = '{4'hD, 8'h25, 0, 0};
        tbl[6]  = '{4'hD, 8'h25, 0, 0};
        tbl[7]  = '{4'hD, 8'h25, 1, 0};
        tbl[8]  = '{4'hF, 8'h0D, 0, 0};
        tbl[9]  = '{4'hF, 8'h0D, 0, 0};
        tbl[10] = '{4'hF, 8'h0D, 0, 0};
        tbl[11] = '{4'hF, 8'h0D, 1, 0};
        tbl[12] = '{4'hF, 8'h99, 0, 0};
        tbl[13] = '{4'h7, 8'h99, 0, 0};
        tbl[14] = '{4'h7, 8'h99, 0, 0};
        tbl[15] = '{4'h7, 8'h99, 1, 1};

        reset      = 1'b1;
        dig_bus    = {dg(1, 4'h4, 1), dg(0, 4'h3, 1), dg(1, 4'h2, 1), dg(1, 4'h1, 1)};
        bright     = 2'd3;
        blink_mask = 4'b0000;

        repeat (3) begin
            step();
            chk("reset_hold", 4'hF, 8'hFF, 0, 0);
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("post_reset", 4'hF, 8'hFF, i == 3, 0);
            step();
        end

        // two full frames at full brightness
        for (int f = 0; f < 2; f++)
            for (int e = 0; e < 16; e++) begin
                chk($sformatf("frame%0d_vec%0d", f, e), tbl[e].an, tbl[e].dec, tbl[e].s, tbl[e].f);
                step();
            end

        // bright=1: lit only where pwm_cnt (= cycle mod 4) <= 1
        bright = 2'd1;
        chk("b1_blank", 4'hF, 8'h9F, 0, 0); step();
        chk("b1_pwm1",  4'hE, 8'h9F, 0, 0); step();
        chk("b1_pwm2",  4'hF, 8'h9F, 0, 0); step();
        chk("b1_pwm3",  4'hF, 8'h9F, 1, 0);
        bright = 2'd2;
        step();
        chk("b2_blank", 4'hF, 8'h25, 0, 0); step();
        chk("b2_pwm1",  4'hD, 8'h25, 0, 0); step();
        chk("b2_pwm2",  4'hD, 8'h25, 0, 0); step();
        chk("b2_pwm3",  4'hF, 8'h25, 1, 0);
        bright = 2'd3;
        repeat (5) step();

        // digit 3 disabled mid-slot: not shown until its next slot
        chk("latch_blank", 4'hF, 8'h99, 0, 0);
        dig_bus[23] = 1'b0;
        step(); chk("latch_hold1", 4'h7, 8'h99, 0, 0);
        step(); chk("latch_hold2", 4'h7, 8'h99, 0, 0);
        step(); chk("latch_end",   4'h7, 8'h99, 1, 1);
        repeat (13) step();
        chk("en0_dec", 4'hF, 8'h99, 0, 0); step();
        chk("en0_an",  4'hF, 8'h99, 0, 0);

        // reset in the middle of a slot
        reset = 1'b1;
        step(); chk("mid_reset1", 4'hF, 8'hFF, 0, 0);
        step(); chk("mid_reset2", 4'hF, 8'hFF, 0, 0);
        reset = 1'b0;
        dig_bus[23] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("mid_post", 4'hF, 8'hFF, i == 3, 0);
            step();
        end
        chk("first_dig0_blank", 4'hF, 8'h9F, 0, 0); step();
        chk("first_dig0_lit",   4'hE, 8'h9F, 0, 0);

        // blink on digit 0: shown frames 0-1, blanked 2-3 (mask ignored when blink is not built)
        reset = 1'b1;
        step();
        reset      = 1'b0;
        blink_mask = 4'b0001;
        repeat (5) step();
        for (int f = 0; f < 5; f++) begin
`ifdef DSPL_BLINK_EN
            chk($sformatf("blink_f%0d", f), (f == 2 || f == 3) ? 4'hF : 4'hE, 8'h9F, 0, 0);
`else
            chk($sformatf("blink_f%0d", f), 4'hE, 8'h9F, 0, 0);
`endif
            repeat (16) step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
